// File: rtl/eth_phy_10g_tx_if.sv
// 10GBASE-R transmit SERDES interface: self-synchronous payload scrambler, optional
// inverted PRBS31 test pattern, optional bit reversal and an unreset output pipeline.
module eth_phy_10g_tx_if #(
    parameter int DATA_WIDTH        = 64,
    parameter int HDR_WIDTH         = 2,
    parameter int BIT_REVERSE       = 0,
    parameter int SCRAMBLER_DISABLE = 0,
    parameter int PRBS31_ENABLE     = 0,
    parameter int SERDES_PIPELINE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] encoded_tx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
    output logic [DATA_WIDTH-1:0] serdes_tx_data,
    output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
    input  logic                  tx_prbs31_enable
);

    if (DATA_WIDTH != 64) begin : g_bad_data_width
        $error("eth_phy_10g_tx_if: DATA_WIDTH must be 64");
    end
    if (HDR_WIDTH != 2) begin : g_bad_hdr_width
        $error("eth_phy_10g_tx_if: HDR_WIDTH must be 2");
    end

    // ext[57:0] is the stored history (oldest first); each new bit taps 39 and 58 bits back.
    function automatic logic [63:0] scramble(input logic [57:0] state, input logic [63:0] din);
        logic [121:0] ext;
        ext        = '0;
        ext[57:0]  = state;
        for (int i = 0; i < 64; i++) begin
            ext[58+i] = din[i] ^ ext[i+19] ^ ext[i];
        end
        return ext[121:58];
    endfunction

    // Fibonacci x^31+x^28+1: new bit = bit 31 back ^ bit 28 back; state oldest first.
    function automatic logic [65:0] prbs31_step(input logic [30:0] state);
        logic [96:0] ext;
        ext       = '0;
        ext[30:0] = state;
        for (int n = 0; n < 66; n++) begin
            ext[31+n] = ext[n] ^ ext[n+3];
        end
        return ext[96:31];
    endfunction

    logic [57:0] scr_state_q, scr_state_d;
    logic [63:0] scrambled_data;
    logic [63:0] out_data_q, out_data_d;
    logic [1:0]  out_hdr_q, out_hdr_d;
    logic        prbs_active;
    logic [65:0] prbs_word;
    logic [63:0] line_data;
    logic [1:0]  line_hdr;

    always_comb begin
        scrambled_data = scramble(scr_state_q, encoded_tx_data);
        scr_state_d    = scrambled_data[63:6];
    end

    if (PRBS31_ENABLE != 0) begin : g_prbs
        logic [30:0] prbs_state_q, prbs_state_d;
        logic        prbs_active_q, prbs_active_d;
        logic [30:0] prbs_seed;
        logic [65:0] prbs_bits;

        // A fresh activation always restarts from the all-ones seed.
        always_comb begin
            prbs_active   = tx_prbs31_enable;
            prbs_seed     = prbs_active_q ? prbs_state_q : 31'h7fffffff;
            prbs_bits     = prbs31_step(prbs_seed);
            prbs_word     = ~prbs_bits;
            prbs_state_d  = prbs_active ? prbs_bits[65:35] : prbs_state_q;
            prbs_active_d = prbs_active;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                prbs_state_q  <= 31'h7fffffff;
                prbs_active_q <= 1'b0;
            end else begin
                prbs_state_q  <= prbs_state_d;
                prbs_active_q <= prbs_active_d;
            end
        end
    end else begin : g_no_prbs
        logic unused_prbs_enable;
        assign unused_prbs_enable = tx_prbs31_enable;
        assign prbs_active        = 1'b0;
        assign prbs_word          = '0;
    end

    always_comb begin
        out_data_d = (SCRAMBLER_DISABLE != 0) ? encoded_tx_data : scrambled_data;
        out_hdr_d  = encoded_tx_hdr;
        if (prbs_active) begin
            out_data_d = prbs_word[65:2];
            out_hdr_d  = prbs_word[1:0];
        end
    end

    // Header 2'b00 during reset is deliberately invalid so the far end drops lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scr_state_q <= '1;
            out_data_q  <= '0;
            out_hdr_q   <= 2'b00;
        end else begin
            scr_state_q <= scr_state_d;
            out_data_q  <= out_data_d;
            out_hdr_q   <= out_hdr_d;
        end
    end

    if (BIT_REVERSE != 0) begin : g_reverse
        always_comb begin
            line_data = '0;
            line_hdr  = '0;
            for (int i = 0; i < 64; i++) begin
                line_data[i] = out_data_q[63-i];
            end
            for (int i = 0; i < 2; i++) begin
                line_hdr[i] = out_hdr_q[1-i];
            end
        end
    end else begin : g_no_reverse
        assign line_data = out_data_q;
        assign line_hdr  = out_hdr_q;
    end

    if (SERDES_PIPELINE > 0) begin : g_pipe
        logic [63:0] pipe_data_q [SERDES_PIPELINE];
        logic [63:0] pipe_data_d [SERDES_PIPELINE];
        logic [1:0]  pipe_hdr_q  [SERDES_PIPELINE];
        logic [1:0]  pipe_hdr_d  [SERDES_PIPELINE];

        always_comb begin
            pipe_data_d[0] = line_data;
            pipe_hdr_d[0]  = line_hdr;
            for (int k = 1; k < SERDES_PIPELINE; k++) begin
                pipe_data_d[k] = pipe_data_q[k-1];
                pipe_hdr_d[k]  = pipe_hdr_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            pipe_data_q <= pipe_data_d;
            pipe_hdr_q  <= pipe_hdr_d;
        end

        assign serdes_tx_data = pipe_data_q[SERDES_PIPELINE-1];
        assign serdes_tx_hdr  = pipe_hdr_q[SERDES_PIPELINE-1];
    end else begin : g_no_pipe
        assign serdes_tx_data = line_data;
        assign serdes_tx_hdr  = line_hdr;
    end

endmodule

// File: tb/tb_eth_phy_10g_tx_if.sv
// Randomized bench for eth_phy_10g_tx_if: a bit-serial line model plus an RX-side
// descrambler and PRBS31 checker judge a scrambling DUT and a reversed passthrough DUT.
module tb_eth_phy_10g_tx_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] enc_data;
    logic [1:0]  enc_hdr;
    logic        prbs_en;
    logic [63:0] dut_data, rev_data;
    logic [1:0]  dut_hdr, rev_hdr;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  hdr;
        logic [63:0] rdata;
        logic [1:0]  rhdr;
        logic [63:0] src;
        bit          rx_ok;
        bit          prbs;
        bit          prbs_first;
    } exp_t;

    exp_t exp_q[$];
    bit   scr_hist[$];
    bit   prbs_hist[$];
    bit   rx_hist[$];
    bit   prbs_rx[$];
    bit   active_last;
    bit   prev_normal;
    int   prbs_errors;
    int   check_count;
    int   pass_count;

    eth_phy_10g_tx_if #(
        .DATA_WIDTH(64), .HDR_WIDTH(2), .BIT_REVERSE(0), .SCRAMBLER_DISABLE(0),
        .PRBS31_ENABLE(1), .SERDES_PIPELINE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .encoded_tx_data(enc_data), .encoded_tx_hdr(enc_hdr),
        .serdes_tx_data(dut_data), .serdes_tx_hdr(dut_hdr), .tx_prbs31_enable(prbs_en)
    );

    eth_phy_10g_tx_if #(
        .DATA_WIDTH(64), .HDR_WIDTH(2), .BIT_REVERSE(1), .SCRAMBLER_DISABLE(1),
        .PRBS31_ENABLE(1), .SERDES_PIPELINE(0)
    ) dut_rev (
        .clk(clk), .rst_n(rst_n), .encoded_tx_data(enc_data), .encoded_tx_hdr(enc_hdr),
        .serdes_tx_data(rev_data), .serdes_tx_hdr(rev_hdr), .tx_prbs31_enable(prbs_en)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[63-i];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs !== exp)
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        else
            pass_count++;
    endtask

    // Drives one block, advances the line model, clocks once and compares both DUTs.
    task automatic applyStimulus(input logic rst_v, input logic prbs_v,
                                 input logic [63:0] d, input logic [1:0] h);
        exp_t        e;
        bit          b;
        bit          x;
        logic [65:0] w;
        logic [63:0] rec;
        logic [65:0] line;
        rst_n    = rst_v;
        prbs_en  = prbs_v;
        enc_data = d;
        enc_hdr  = h;
        e.src = d;  e.rx_ok = 0;  e.prbs = 0;  e.prbs_first = 0;
        e.data = '0; e.hdr = '0; e.rdata = '0; e.rhdr = '0;
        if (!rst_v) begin
            scr_hist.delete();
            repeat (58) scr_hist.push_back(1'b1);
            active_last = 0;
            prev_normal = 0;
        end else begin
            for (int i = 0; i < 64; i++) begin
                b = d[i] ^ scr_hist[scr_hist.size()-39] ^ scr_hist[scr_hist.size()-58];
                e.data[i] = b;
                scr_hist.push_back(b);
                void'(scr_hist.pop_front());
            end
            if (prbs_v) begin
                if (!active_last) begin
                    prbs_hist.delete();
                    repeat (31) prbs_hist.push_back(1'b1);
                    e.prbs_first = 1;
                end
                for (int k = 0; k < 66; k++) begin
                    x = prbs_hist[prbs_hist.size()-31] ^ prbs_hist[prbs_hist.size()-28];
                    prbs_hist.push_back(x);
                    void'(prbs_hist.pop_front());
                    w[k] = ~x;
                end
                e.data  = w[65:2];  e.hdr  = w[1:0];
                e.rdata = w[65:2];  e.rhdr = w[1:0];
                e.prbs  = 1;
                active_last = 1;
                prev_normal = 0;
            end else begin
                e.hdr   = h;
                e.rdata = d;
                e.rhdr  = h;
                e.rx_ok = prev_normal;
                active_last = 0;
                prev_normal = 1;
            end
        end
        exp_q.push_back(e);
        if (exp_q.size() > 3) void'(exp_q.pop_front());

        @(posedge clk);
        #1;
        checkOutput("rev_data", rev_data, rev64(e.rdata));
        checkOutput("rev_hdr", {62'b0, rev_hdr}, {62'b0, e.rhdr[0], e.rhdr[1]});
        if (exp_q.size() == 3) begin
            checkOutput("line_data", dut_data, exp_q[0].data);
            checkOutput("line_hdr", {62'b0, dut_hdr}, {62'b0, exp_q[0].hdr});
            if (exp_q[0].prbs) begin
                if (exp_q[0].prbs_first) prbs_rx.delete();
                line = {dut_data, dut_hdr};
                for (int k = 0; k < 66; k++) begin
                    x = ~line[k];
                    if (prbs_rx.size() == 31 && x != (prbs_rx[0] ^ prbs_rx[3])) prbs_errors++;
                    prbs_rx.push_back(x);
                    if (prbs_rx.size() > 31) void'(prbs_rx.pop_front());
                end
            end
            for (int i = 0; i < 64; i++) begin
                b = dut_data[i];
                rec[i] = b ^ rx_hist[rx_hist.size()-39] ^ rx_hist[rx_hist.size()-58];
                rx_hist.push_back(b);
                void'(rx_hist.pop_front());
            end
            if (exp_q[0].rx_ok) checkOutput("rx_recover", rec, exp_q[0].src);
        end
    endtask

    function automatic logic [1:0] rand_hdr();
        return ($urandom_range(1) == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic randomBlocks(input int count, input logic prbs_v);
        for (int n = 0; n < count; n++) begin
            if ($urandom_range(3) == 0)
                applyStimulus(1'b1, prbs_v, 64'h1e, 2'b10);
            else
                applyStimulus(1'b1, prbs_v, {$urandom, $urandom}, rand_hdr());
        end
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        prbs_errors = 0;
        active_last = 0;
        prev_normal = 0;
        repeat (58) rx_hist.push_back(1'b0);
        repeat (58) scr_hist.push_back(1'b1);

        repeat (4) applyStimulus(1'b0, 1'b0, {$urandom, $urandom}, rand_hdr());
        checkOutput("reset_data", dut_data, 64'h0);
        checkOutput("reset_hdr", {62'b0, dut_hdr}, 64'h0);

        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'b1, 1'b0, 64'h0, 2'b01);
            if (n == 2) checkOutput("scr_first_zero_block", dut_data, 64'h03ffff8000000000);
        end

        randomBlocks(400, 1'b0);

        applyStimulus(1'b1, 1'b0, 64'h1, 2'b01);
        checkOutput("rev_const_data", rev_data, 64'h8000000000000000);
        checkOutput("rev_const_hdr", {62'b0, rev_hdr}, 64'h2);
        applyStimulus(1'b1, 1'b0, 64'h0123456789abcdef, 2'b01);

        randomBlocks(300, 1'b1);
        randomBlocks(20, 1'b0);
        randomBlocks(60, 1'b1);
        randomBlocks(10, 1'b0);
        checkOutput("prbs_rx_errors", 64'(prbs_errors), 64'h0);

        randomBlocks(20, 1'b0);
        applyStimulus(1'b0, 1'b0, {$urandom, $urandom}, rand_hdr());
        randomBlocks(30, 1'b0);
        randomBlocks(3, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
